// File: rtl/vram_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// vram_arbiter_pkg
// Shared definitions for the VRAM port arbiter:
//   - default address / data widths of the text/font RAM
//   - default posted-write FIFO depth and statistic counter width
//   - CPU-side FSM state encoding
// -----------------------------------------------------------------------------
package vram_arbiter_pkg;

    localparam int VRAM_AW       = 12;
    localparam int VRAM_DW       = 16;
    localparam int VRAM_WF_DEPTH = 4;
    localparam int VRAM_STAT_W   = 8;

    typedef enum logic [1:0] {
        C_IDLE    = 2'd0,
        C_RD_WAIT = 2'd1,
        C_RD_DATA = 2'd2,
        C_ACK     = 2'd3
    } cpu_state_e;

endpackage

// File: rtl/vram_arbiter_if.sv
// -----------------------------------------------------------------------------
// vram_arbiter_if
// CPU MMIO bus between the picosoc decode and the VRAM arbiter.
//   sel    : request, held high by the master until ready
//   wstrb  : byte strobes, all zero means read
//   addr   : word address
//   wdata  : write data
//   ready  : one-cycle completion pulse from the arbiter
//   rdata  : read data, valid while ready is high
// Modports: master (CPU side), slave (arbiter side).
// -----------------------------------------------------------------------------
interface vram_arbiter_if #(
    parameter int AW = 12,
    parameter int DW = 16
) ();
    logic              sel;
    logic [DW/8-1:0]   wstrb;
    logic [AW-1:0]     addr;
    logic [DW-1:0]     wdata;
    logic              ready;
    logic [DW-1:0]     rdata;

    modport master (
        output sel, wstrb, addr, wdata,
        input  ready, rdata
    );

    modport slave (
        input  sel, wstrb, addr, wdata,
        output ready, rdata
    );
endinterface

// File: rtl/vram_arbiter_sync_fifo.sv
// -----------------------------------------------------------------------------
// vram_arbiter_sync_fifo
// Small synchronous FIFO holding posted CPU writes. The head entry is visible
// combinationally on o_dout so the arbiter can drive the RAM in the same cycle
// it decides to pop.
// Ports:
//   clk, resetn : clock, synchronous active-low reset (flushes all entries)
//   i_push      : write i_din; accepted when not full or when popping
//   i_pop       : drop the head entry; ignored when empty
//   i_din       : entry to store
//   o_dout      : current head entry
//   o_full      : DEPTH entries stored
//   o_empty     : no entries stored
// -----------------------------------------------------------------------------
module vram_arbiter_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_full,
    output logic             o_empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [PW:0]      r_count;

    logic w_do_pop;
    logic w_do_push;

    assign o_full    = (r_count == (PW+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_dout    = r_mem[r_rd_ptr];

    // A full FIFO can still take a push in the cycle its head leaves.
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (w_do_push && (r_wr_ptr == PW'(gi))) begin
                    r_mem[gi] <= i_din;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= (r_wr_ptr == PW'(DEPTH-1)) ? '0 : r_wr_ptr + PW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= (r_rd_ptr == PW'(DEPTH-1)) ? '0 : r_rd_ptr + PW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (PW+1)'(1);
                2'b01:   r_count <= r_count - (PW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/vram_arbiter.sv
// -----------------------------------------------------------------------------
// vram_arbiter
// Shares the single port of the text/font dpram between the display fetch
// engine (absolute priority) and the CPU MMIO bus. CPU writes are posted into
// a FIFO; a CPU read waits until that FIFO is drained so it always observes
// the most recent posted value.
// Ports:
//   clk, resetn       : clock, synchronous active-low reset
//   cpu               : CPU bus (slave modport of vram_arbiter_if)
//   i_disp_req        : display read request for this cycle
//   i_disp_addr       : display read address
//   o_disp_rvalid     : display data valid (one cycle after the grant)
//   o_disp_rdata      : RAM read data passed straight through
//   o_mem_en/we/be    : RAM port enable, write enable, byte enables
//   o_mem_addr/wdata  : RAM address, write data
//   i_mem_rdata       : RAM read data, one cycle after a read
//   o_stat_wait_max   : longest CPU stall in cycles, saturating
//   i_stat_clr        : clears o_stat_wait_max
// -----------------------------------------------------------------------------
module vram_arbiter
    import vram_arbiter_pkg::*;
#(
    parameter int AW       = VRAM_AW,
    parameter int DW       = VRAM_DW,
    parameter int WF_DEPTH = VRAM_WF_DEPTH,
    parameter int STAT_W   = VRAM_STAT_W
) (
    input  logic                clk,
    input  logic                resetn,
    vram_arbiter_if.slave       cpu,
    input  logic                i_disp_req,
    input  logic [AW-1:0]       i_disp_addr,
    output logic                o_disp_rvalid,
    output logic [DW-1:0]       o_disp_rdata,
    output logic                o_mem_en,
    output logic                o_mem_we,
    output logic [DW/8-1:0]     o_mem_be,
    output logic [AW-1:0]       o_mem_addr,
    output logic [DW-1:0]       o_mem_wdata,
    input  logic [DW-1:0]       i_mem_rdata,
    output logic [STAT_W-1:0]   o_stat_wait_max,
    input  logic                i_stat_clr
);

    localparam int BW = DW / 8;
    localparam int FW = AW + DW + BW;

    cpu_state_e       r_state;
    cpu_state_e       w_state_next;

    logic [AW-1:0]    r_rd_addr;
    logic [DW-1:0]    r_cpu_rdata;
    logic             r_disp_rvalid;
    logic [STAT_W-1:0] r_wait_cnt;
    logic [STAT_W-1:0] r_stat_wait_max;

    logic [FW-1:0]    w_fifo_din;
    logic [FW-1:0]    w_fifo_dout;
    logic             w_fifo_full;
    logic             w_fifo_empty;
    logic             w_fifo_pop;
    logic             w_push;

    logic [AW-1:0]    w_head_addr;
    logic [DW-1:0]    w_head_wdata;
    logic [BW-1:0]    w_head_be;

    logic             w_disp_grant;
    logic             w_rd_grant;
    logic             w_wr_req;
    logic             w_rd_req;
    logic             w_wr_blocked;

    // ---------------------------------------------------------------- FIFO --
    assign w_fifo_din   = {cpu.addr, cpu.wdata, cpu.wstrb};
    assign w_head_addr  = w_fifo_dout[FW-1 -: AW];
    assign w_head_wdata = w_fifo_dout[DW+BW-1 -: DW];
    assign w_head_be    = w_fifo_dout[BW-1:0];

    vram_arbiter_sync_fifo #(
        .WIDTH (FW),
        .DEPTH (WF_DEPTH)
    ) u_wr_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .i_push  (w_push),
        .i_pop   (w_fifo_pop),
        .i_din   (w_fifo_din),
        .o_dout  (w_fifo_dout),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    // ---------------------------------------------------------- arbitration --
    // Display always wins. A CPU read only issues once every posted write has
    // reached the RAM, so read and pop can never be requested together.
    assign w_disp_grant = resetn && i_disp_req;
    assign w_rd_grant   = resetn && !i_disp_req && (r_state == C_RD_WAIT) && w_fifo_empty;
    assign w_fifo_pop   = resetn && !i_disp_req && !w_fifo_empty;

    always_comb begin
        o_mem_en    = w_disp_grant || w_rd_grant || w_fifo_pop;
        o_mem_we    = w_fifo_pop;
        o_mem_be    = w_fifo_pop ? w_head_be : '0;
        o_mem_wdata = w_head_wdata;
        if (w_disp_grant) begin
            o_mem_addr = i_disp_addr;
        end else if (w_rd_grant) begin
            o_mem_addr = r_rd_addr;
        end else begin
            o_mem_addr = w_head_addr;
        end
    end

    assign o_disp_rdata = i_mem_rdata;
    assign o_disp_rvalid = r_disp_rvalid;

    // ------------------------------------------------------------- CPU FSM --
    assign w_wr_req     = (r_state == C_IDLE) && cpu.sel && (cpu.wstrb != '0);
    assign w_rd_req     = (r_state == C_IDLE) && cpu.sel && (cpu.wstrb == '0);
    assign w_push       = w_wr_req && (!w_fifo_full || w_fifo_pop);
    assign w_wr_blocked = w_wr_req && !w_push;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= C_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            C_IDLE: begin
                if (w_push) begin
                    w_state_next = C_ACK;
                end else if (w_rd_req) begin
                    w_state_next = C_RD_WAIT;
                end
            end
            C_RD_WAIT: begin
                if (w_rd_grant) begin
                    w_state_next = C_RD_DATA;
                end
            end
            C_RD_DATA: w_state_next = C_ACK;
            C_ACK:     w_state_next = C_IDLE;
            default:   w_state_next = C_IDLE;
        endcase
    end

    // ready is decoded from the state register, so it is glitch-free and
    // exactly one cycle long.
    always_comb begin
        cpu.ready = (r_state == C_ACK);
    end

    assign cpu.rdata = r_cpu_rdata;

    // ------------------------------------------------------------ datapath --
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_rd_addr     <= '0;
            r_cpu_rdata   <= '0;
            r_disp_rvalid <= 1'b0;
        end else begin
            r_disp_rvalid <= w_disp_grant;
            if (w_rd_req) begin
                r_rd_addr <= cpu.addr;
            end
            if (r_state == C_RD_DATA) begin
                r_cpu_rdata <= i_mem_rdata;
            end
        end
    end

    // ---------------------------------------------------------- statistics --
    // The max tracker samples the counter before it is cleared on entry to
    // C_ACK, so the last stall cycle of a transaction is always included.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_wait_cnt <= '0;
        end else if ((w_state_next == C_ACK) && (r_state != C_ACK)) begin
            r_wait_cnt <= '0;
        end else if (((r_state == C_RD_WAIT) || w_wr_blocked) && (r_wait_cnt != '1)) begin
            r_wait_cnt <= r_wait_cnt + STAT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn || i_stat_clr) begin
            r_stat_wait_max <= '0;
        end else if (r_wait_cnt > r_stat_wait_max) begin
            r_stat_wait_max <= r_wait_cnt;
        end
    end

    assign o_stat_wait_max = r_stat_wait_max;

endmodule
